dcache_req_serializer: RTL and testbench
========================================

// Module: dcache_req_serializer
// PURPOSE
//  Sits directly downstream of the pipeline's per-thread dcache request/response ports.
//  Accepts one NUM_THREADS-wide LSU batch and issues its active lanes one per cycle to a
//  single-port memory. Gathers the read data (any return order) into one warp-wide
//  response carrying tmask/data/tag. Stores complete silently.
// PARAMETERS
//  NUM_THREADS  4   lanes per batch (>=2)
//  TAG_WIDTH    8   core tag width (matches DCACHE_CORE_TAG_WIDTH)
//  ADDR_WIDTH   30  word address width
//  LANE_BITS    $clog2(NUM_THREADS)  derived; not overridable
// PORTS
//  clk               in   1                  clock
//  reset             in   1                  reset, asynchronous, active-low (0 = reset)
//  dcache_req_valid  in   NUM_THREADS        per-lane request valid
//  dcache_req_rw     in   NUM_THREADS        per-lane 1=store 0=load
//  dcache_req_byteen in   NUM_THREADS*4      per-lane byte enables
//  dcache_req_addr   in   NUM_THREADS*ADDR_WIDTH  per-lane word address
//  dcache_req_data   in   NUM_THREADS*32     per-lane store data
//  dcache_req_tag    in   NUM_THREADS*TAG_WIDTH   per-lane tag
//  dcache_req_ready  out  NUM_THREADS        per-lane ready
//  dcache_rsp_valid  out  1                  gathered load response valid
//  dcache_rsp_tmask  out  NUM_THREADS        lanes carried by response
//  dcache_rsp_data   out  NUM_THREADS*32     per-lane load data
//  dcache_rsp_tag    out  TAG_WIDTH          batch tag
//  dcache_rsp_ready  in   1                  pipeline accepts response
//  mem_req_valid/_rw out  1 each             serialized request, store flag
//  mem_req_byteen    out  4                  byte enables
//  mem_req_addr      out  ADDR_WIDTH         word address
//  mem_req_data      out  32                 store data
//  mem_req_tag       out  LANE_BITS          originating lane index
//  mem_req_ready     in   1                  memory accepts request
//  mem_rsp_valid     in   1                  load data returning
//  mem_rsp_data      in   32                 load data
//  mem_rsp_tag       in   LANE_BITS          lane index of returning data
//  mem_rsp_ready     out  1                  always 1 (see below)
// BEHAVIOUR
//  - Reset: state=IDLE, all outputs 0 except dcache_req_ready = all-ones and mem_rsp_ready=1.
//  - Batch rw and tag are taken from the lowest-index valid lane; other lanes are ignored for them.
//  - FSM IDLE -> ISSUE -> (WAIT) -> (RESP) -> IDLE:
//    IDLE:  ready = all-ones. Accept if |dcache_req_valid.
//           Register valid mask, addr, data, byteen, rw and tag. Go to ISSUE.
//    ISSUE: ready=0. mem_req_valid=1 for the lowest remaining lane, fully registered.
//           The first request appears the cycle after accept.
//           Lane leaves the mask on mem_req_valid&mem_req_ready; next lane shown the next cycle.
//           Last lane accepted: store -> IDLE; load -> WAIT.
//    WAIT:  each mem_rsp writes data[mem_rsp_tag] and sets the got bit.
//           got==tmask -> RESP the next cycle.
//    RESP:  dcache_rsp_valid=1 with tmask/data/tag held stable until dcache_rsp_ready.
//           Then IDLE; the next batch can be accepted the following cycle.
//  - Throughput with mem_req_ready=1: N active lanes -> N consecutive request cycles.
//  - Load rsp may overlap ISSUE (response before later lanes are issued). It is captured.
//  - A duplicate response for a lane already received, or one for a lane not in tmask:
//    ignored; assertion fires in simulation.
//  - mem_rsp arriving in IDLE/RESP: accepted and discarded (covers stale responses after reset).
//  - Reset mid-batch: immediate return to reset values; partial batch lost.
//  - mem_req_ready low: request held stable (valid/addr/data/tag unchanged).
// CONFIGURATION
//  DCACHE_SER_PERF_EN defined adds outputs perf_batches[31:0] and perf_stall_cycles[31:0].
//   perf_batches: +1 per accepted batch.
//   perf_stall_cycles: +1 per cycle with mem_req_valid&!mem_req_ready.
//   Both wrap at 2^32 and reset to 0.
//  Undefined: ports and counters absent; functional behaviour identical.
// TESTING
//  1. Load, valid=4'b1111, addr=0x10..0x13, mem ready=1, in-order rsp
//     -> 4 mem reqs cycles 1-4, tags 0..3; rsp tmask=1111, data per lane.
//  2. Store, valid=4'b0101 -> mem reqs lane0 then lane2, rw=1.
//     No dcache_rsp; ready all-ones again the cycle after the lane2 handshake.
//  3. Load valid=4'b1011, responses tagged 3,0,1
//     -> data lands in the correct lanes; rsp tmask=1011, tag = lane0 tag.
//  4. mem_req_ready low 3 cycles on lane1 -> lane1 request stable for 4 cycles.
//     perf_stall_cycles=3 (PERF_EN).
//  5. dcache_rsp_ready held low 5 cycles in RESP -> rsp stable; dcache_req_ready stays 0.
//  6. Reset asserted in WAIT, then a late mem_rsp
//     -> IDLE, rsp discarded, no dcache_rsp_valid.
//     A fresh batch then completes correctly.

Source files
------------

// File: rtl/dcache_req_serializer.sv
// Serializes one NUM_THREADS-wide dcache batch onto a single-port memory and gathers load data.
// Optional perf counters (perf_batches, perf_stall_cycles) are enabled by defining DCACHE_SER_PERF_EN.
module dcache_req_serializer #(
  parameter int  NUM_THREADS = 4,
  parameter int  TAG_WIDTH   = 8,
  parameter int  ADDR_WIDTH  = 30,
  localparam int LANE_BITS   = $clog2(NUM_THREADS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_THREADS-1:0]            dcache_req_valid,
  input  logic [NUM_THREADS-1:0]            dcache_req_rw,
  input  logic [NUM_THREADS*4-1:0]          dcache_req_byteen,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0] dcache_req_addr,
  input  logic [NUM_THREADS*32-1:0]         dcache_req_data,
  input  logic [NUM_THREADS*TAG_WIDTH-1:0]  dcache_req_tag,
  output logic [NUM_THREADS-1:0]            dcache_req_ready,
  output logic                              dcache_rsp_valid,
  output logic [NUM_THREADS-1:0]            dcache_rsp_tmask,
  output logic [NUM_THREADS*32-1:0]         dcache_rsp_data,
  output logic [TAG_WIDTH-1:0]              dcache_rsp_tag,
  input  logic                              dcache_rsp_ready,
  output logic                              mem_req_valid,
  output logic                              mem_req_rw,
  output logic [3:0]                        mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [31:0]                       mem_req_data,
  output logic [LANE_BITS-1:0]              mem_req_tag,
  input  logic                              mem_req_ready,
  input  logic                              mem_rsp_valid,
  input  logic [31:0]                       mem_rsp_data,
  input  logic [LANE_BITS-1:0]              mem_rsp_tag,
  output logic                              mem_rsp_ready
`ifdef DCACHE_SER_PERF_EN
  ,
  output logic [31:0]                       perf_batches,
  output logic [31:0]                       perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state;
  logic [NUM_THREADS-1:0] pend;
  logic [NUM_THREADS-1:0] tmask_r;
  logic [NUM_THREADS-1:0] got;
  logic                   rw_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [ADDR_WIDTH-1:0]  addr_q   [NUM_THREADS];
  logic [31:0]            wdata_q  [NUM_THREADS];
  logic [3:0]             byteen_q [NUM_THREADS];
  logic [31:0]            rdata_q  [NUM_THREADS];

  logic [LANE_BITS-1:0]   acc_lane;
  logic [LANE_BITS-1:0]   next_lane;
  logic [NUM_THREADS-1:0] pend_next;
  logic [NUM_THREADS-1:0] got_next;
  logic                   rsp_live;
  logic                   rsp_in_range;
  logic                   rsp_take;

  function automatic logic [LANE_BITS-1:0] lowest_lane(input logic [NUM_THREADS-1:0] m);
    lowest_lane = '0;
    for (int unsigned i = NUM_THREADS; i > 0; i--)
      if (m[i-1]) lowest_lane = LANE_BITS'(i - 1);
  endfunction

  always_comb begin
    acc_lane     = lowest_lane(dcache_req_valid);
    pend_next    = pend & ~(NUM_THREADS'(1) << mem_req_tag);
    next_lane    = lowest_lane(pend_next);
    // Responses only count while a load batch is outstanding; anything else is stale.
    rsp_live     = mem_rsp_valid && !rw_r && (state == S_ISSUE || state == S_WAIT);
    rsp_in_range = {1'b0, mem_rsp_tag} < (LANE_BITS+1)'(NUM_THREADS);
    rsp_take     = rsp_live && rsp_in_range && tmask_r[mem_rsp_tag] && !got[mem_rsp_tag];
    got_next     = rsp_take ? (got | (NUM_THREADS'(1) << mem_rsp_tag)) : got;
  end

  always_comb begin
    dcache_rsp_data = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++)
      dcache_rsp_data[i*32 +: 32] = rdata_q[i];
  end

  assign dcache_rsp_tmask = tmask_r;
  assign dcache_rsp_tag   = tag_r;
  assign mem_rsp_ready    = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      pend             <= '0;
      tmask_r          <= '0;
      got              <= '0;
      rw_r             <= 1'b0;
      tag_r            <= '0;
      dcache_req_ready <= '1;
      dcache_rsp_valid <= 1'b0;
      mem_req_valid    <= 1'b0;
      mem_req_rw       <= 1'b0;
      mem_req_byteen   <= '0;
      mem_req_addr     <= '0;
      mem_req_data     <= '0;
      mem_req_tag      <= '0;
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        addr_q[i]   <= '0;
        wdata_q[i]  <= '0;
        byteen_q[i] <= '0;
        rdata_q[i]  <= '0;
      end
    end else begin
      if (rsp_take) rdata_q[mem_rsp_tag] <= mem_rsp_data;
      got <= got_next;
      case (state)
        S_IDLE: begin
          if (|dcache_req_valid) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
              addr_q[i]   <= dcache_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
              wdata_q[i]  <= dcache_req_data[i*32 +: 32];
              byteen_q[i] <= dcache_req_byteen[i*4 +: 4];
              rdata_q[i]  <= '0;
            end
            pend             <= dcache_req_valid;
            tmask_r          <= dcache_req_valid;
            got              <= '0;
            rw_r             <= dcache_req_rw[acc_lane];
            tag_r            <= dcache_req_tag[acc_lane*TAG_WIDTH +: TAG_WIDTH];
            // First lane is loaded straight from the inputs so it issues the cycle after accept.
            mem_req_valid    <= 1'b1;
            mem_req_rw       <= dcache_req_rw[acc_lane];
            mem_req_addr     <= dcache_req_addr[acc_lane*ADDR_WIDTH +: ADDR_WIDTH];
            mem_req_data     <= dcache_req_data[acc_lane*32 +: 32];
            mem_req_byteen   <= dcache_req_byteen[acc_lane*4 +: 4];
            mem_req_tag      <= acc_lane;
            dcache_req_ready <= '0;
            state            <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_valid && mem_req_ready) begin
            pend <= pend_next;
            if (|pend_next) begin
              mem_req_addr   <= addr_q[next_lane];
              mem_req_data   <= wdata_q[next_lane];
              mem_req_byteen <= byteen_q[next_lane];
              mem_req_tag    <= next_lane;
            end else begin
              mem_req_valid <= 1'b0;
              if (rw_r) begin
                dcache_req_ready <= '1;
                state            <= S_IDLE;
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (got_next == tmask_r) begin
            dcache_rsp_valid <= 1'b1;
            state            <= S_RESP;
          end
        end
        S_RESP: begin
          if (dcache_rsp_ready) begin
            dcache_rsp_valid <= 1'b0;
            dcache_req_ready <= '1;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_SER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_batches      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (state == S_IDLE && |dcache_req_valid) perf_batches <= perf_batches + 32'd1;
      if (mem_req_valid && !mem_req_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

  // Duplicate responses and responses for lanes outside the batch are dropped.
  assert property (@(posedge clk) disable iff (!reset)
    rsp_live |-> (rsp_in_range && tmask_r[mem_rsp_tag] && !got[mem_rsp_tag]));

endmodule

// File: tb/tb_dcache_req_serializer.sv
// Randomized bench for dcache_req_serializer: a transaction-level model predicts the
// serialized request stream and the gathered load response; the bench also plays the memory.
module tb_dcache_req_serializer;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int AW = 30;
  localparam int LB = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      dcache_req_valid, dcache_req_rw, dcache_req_ready;
  logic [N*4-1:0]    dcache_req_byteen;
  logic [N*AW-1:0]   dcache_req_addr;
  logic [N*32-1:0]   dcache_req_data, dcache_rsp_data;
  logic [N*TW-1:0]   dcache_req_tag;
  logic              dcache_rsp_valid, dcache_rsp_ready;
  logic [N-1:0]      dcache_rsp_tmask;
  logic [TW-1:0]     dcache_rsp_tag;
  logic              mem_req_valid, mem_req_rw, mem_req_ready;
  logic [3:0]        mem_req_byteen;
  logic [AW-1:0]     mem_req_addr;
  logic [31:0]       mem_req_data, mem_rsp_data;
  logic [LB-1:0]     mem_req_tag, mem_rsp_tag;
  logic              mem_rsp_valid, mem_rsp_ready;
`ifdef DCACHE_SER_PERF_EN
  logic [31:0]       perf_batches, perf_stall_cycles;
`endif

  dcache_req_serializer #(.NUM_THREADS(N), .TAG_WIDTH(TW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .dcache_req_valid(dcache_req_valid), .dcache_req_rw(dcache_req_rw),
    .dcache_req_byteen(dcache_req_byteen), .dcache_req_addr(dcache_req_addr),
    .dcache_req_data(dcache_req_data), .dcache_req_tag(dcache_req_tag),
    .dcache_req_ready(dcache_req_ready),
    .dcache_rsp_valid(dcache_rsp_valid), .dcache_rsp_tmask(dcache_rsp_tmask),
    .dcache_rsp_data(dcache_rsp_data), .dcache_rsp_tag(dcache_rsp_tag),
    .dcache_rsp_ready(dcache_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready)
`ifdef DCACHE_SER_PERF_EN
    , .perf_batches(perf_batches), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          lane;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          model_batches = 0;
  int          model_stalls  = 0;
  int          ord_q[$];

  logic [AW-1:0] l_addr [N];
  logic [31:0]   l_data [N];
  logic [3:0]    l_be   [N];
  logic [TW-1:0] l_tag  [N];
  logic [N-1:0]  l_rw;

  task automatic check_eq(input string what, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, got, exp);
    end
  endtask

  // Memory contents seen by loads: a fixed function of the word address.
  function automatic logic [31:0] mem_val(input logic [AW-1:0] a);
    return {a, 2'b00} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic fill_lanes(input bit use_seq, input logic [AW-1:0] base);
    for (int i = 0; i < N; i++) begin
      l_addr[i] = use_seq ? base + AW'(i) : AW'($urandom);
      l_data[i] = $urandom;
      l_be[i]   = 4'($urandom);
      l_tag[i]  = TW'($urandom);
      l_rw[i]   = 1'($urandom);
    end
  endtask

  task automatic drive_lanes(input logic [N-1:0] vmask);
    dcache_req_valid = vmask;
    dcache_req_rw    = l_rw;
    for (int i = 0; i < N; i++) begin
      dcache_req_addr[i*AW +: AW]  = l_addr[i];
      dcache_req_data[i*32 +: 32]  = l_data[i];
      dcache_req_byteen[i*4 +: 4]  = l_be[i];
      dcache_req_tag[i*TW +: TW]   = l_tag[i];
    end
  endtask

  task automatic scramble_inputs();
    dcache_req_valid  = '0;
    dcache_req_rw     = N'($urandom);
    dcache_req_addr   = {$urandom, $urandom, $urandom, $urandom};
    dcache_req_data   = {$urandom, $urandom, $urandom, $urandom};
    dcache_req_byteen = N*4'($urandom);
    dcache_req_tag    = $urandom;
  endtask

  task automatic check_perf();
`ifdef DCACHE_SER_PERF_EN
    check_eq("perf_batches", perf_batches, model_batches);
    check_eq("perf_stall_cycles", perf_stall_cycles, model_stalls);
`endif
  endtask

  task automatic run_batch(input logic [N-1:0] vmask, input bit is_store, input bit use_seq,
                           input logic [AW-1:0] base, input int stall_pct, input int stall_lane,
                           input int stall_n, input int rsp_hold);
    req_t          exp_q[$];
    int            issued[$];
    req_t          r;
    int            first, rsp_left, stall_left, idx, lane;
    bit            done, ordered;
    logic [TW-1:0] exp_tag;

    fill_lanes(use_seq, base);
    first = -1;
    for (int i = 0; i < N; i++)
      if (vmask[i]) begin
        if (first < 0) first = i;
        exp_q.push_back('{i, l_addr[i], l_data[i], l_be[i]});
      end
    l_rw[first] = is_store;
    exp_tag     = l_tag[first];
    rsp_left    = is_store ? 0 : $countones(vmask);
    ordered     = ord_q.size() > 0;

    check_eq("idle_ready", dcache_req_ready, {N{1'b1}});
    drive_lanes(vmask);
    @(negedge clk);
    model_batches++;
    scramble_inputs();
    stall_left = stall_n;
    done = 1'b0;

    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      mem_rsp_valid = 1'b0;
      check_eq("busy_ready", dcache_req_ready, '0);
      check_eq("early_rsp_valid", dcache_rsp_valid, 1'b0);
      check_eq("req_valid", mem_req_valid, exp_q.size() > 0);

      if (!is_store && issued.size() > 0) begin
        idx = -1;
        if (ordered) begin
          for (int k = 0; k < issued.size(); k++)
            if (issued[k] == ord_q[0]) idx = k;
        end else if ($urandom_range(1) == 1) begin
          idx = $urandom_range(issued.size() - 1);
        end
        if (idx >= 0) begin
          lane = issued[idx];
          issued.delete(idx);
          if (ordered) void'(ord_q.pop_front());
          mem_rsp_valid = 1'b1;
          mem_rsp_tag   = LB'(lane);
          mem_rsp_data  = mem_val(l_addr[lane]);
          rsp_left--;
        end
      end

      if (exp_q.size() > 0) begin
        r = exp_q[0];
        check_eq("req_tag", mem_req_tag, r.lane);
        check_eq("req_addr", mem_req_addr, r.addr);
        check_eq("req_data", mem_req_data, r.data);
        check_eq("req_byteen", mem_req_byteen, r.be);
        check_eq("req_rw", mem_req_rw, is_store);
        if (r.lane == stall_lane && stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
        end else begin
          mem_req_ready = ($urandom_range(99) >= stall_pct);
        end
        if (mem_req_valid && mem_req_ready) begin
          void'(exp_q.pop_front());
          if (!is_store) issued.push_back(r.lane);
        end else if (mem_req_valid) begin
          model_stalls++;
        end
      end else begin
        mem_req_ready = 1'($urandom);
      end
      done = (exp_q.size() == 0) && (rsp_left == 0);
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    ord_q.delete();
    check_eq("issue_done", done, 1'b1);

    if (is_store) begin
      check_eq("store_ready", dcache_req_ready, {N{1'b1}});
      check_eq("store_no_rsp", dcache_rsp_valid, 1'b0);
    end else begin
      for (int w = 0; w < 8 && !dcache_rsp_valid; w++) @(negedge clk);
      check_eq("rsp_valid", dcache_rsp_valid, 1'b1);
      for (int h = 0; h <= rsp_hold; h++) begin
        if (h > 0) begin
          @(negedge clk);
          check_eq("rsp_hold_valid", dcache_rsp_valid, 1'b1);
        end
        check_eq("rsp_tmask", dcache_rsp_tmask, vmask);
        check_eq("rsp_tag", dcache_rsp_tag, exp_tag);
        for (int i = 0; i < N; i++)
          if (vmask[i]) check_eq("rsp_data", dcache_rsp_data[i*32 +: 32], mem_val(l_addr[i]));
        check_eq("rsp_busy_ready", dcache_req_ready, '0);
        dcache_rsp_ready = (h == rsp_hold);
      end
      @(negedge clk);
      dcache_rsp_ready = 1'b0;
      check_eq("rsp_done_valid", dcache_rsp_valid, 1'b0);
      check_eq("rsp_done_ready", dcache_req_ready, {N{1'b1}});
    end
    check_perf();
  endtask

  task automatic check_reset_values(input string what);
    check_eq({what, "_req_ready"}, dcache_req_ready, {N{1'b1}});
    check_eq({what, "_mem_req_valid"}, mem_req_valid, 1'b0);
    check_eq({what, "_rsp_valid"}, dcache_rsp_valid, 1'b0);
    check_eq({what, "_mem_rsp_ready"}, mem_rsp_ready, 1'b1);
  endtask

  initial begin
    reset            = 1'b0;
    scramble_inputs();
    dcache_rsp_ready = 1'b0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_data     = '0;
    mem_rsp_tag      = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    check_eq("reset_rsp_tmask", dcache_rsp_tmask, '0);
    check_eq("reset_mem_req_tag", mem_req_tag, '0);
    reset = 1'b1;
    @(negedge clk);

    // Load of all four lanes, in-order responses, no back-pressure.
    ord_q = '{0, 1, 2, 3};
    run_batch(4'b1111, 1'b0, 1'b1, 30'h10, 0, -1, 0, 0);
    // Store on lanes 0 and 2.
    run_batch(4'b0101, 1'b1, 1'b0, '0, 0, -1, 0, 0);
    // Sparse load with responses returned 3,0,1.
    ord_q = '{3, 0, 1};
    run_batch(4'b1011, 1'b0, 1'b0, '0, 0, -1, 0, 0);
    // Memory stalls lane 1 for three cycles.
    run_batch(4'b1111, 1'b1, 1'b0, '0, 0, 1, 3, 0);
    // Pipeline holds off the gathered response for five cycles.
    run_batch(4'b1111, 1'b0, 1'b0, '0, 0, -1, 0, 5);

    // Reset while waiting for load data, then a stale response arrives.
    fill_lanes(1'b0, '0);
    l_rw = '0;
    drive_lanes(4'b1111);
    @(negedge clk);
    scramble_inputs();
    mem_req_ready = 1'b1;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    model_batches = 0;
    model_stalls  = 0;
    @(negedge clk);
    reset = 1'b1;
    mem_req_ready = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_tag   = 2'd2;
    mem_rsp_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("stale_rsp_valid", dcache_rsp_valid, 1'b0);
      check_eq("stale_req_ready", dcache_req_ready, {N{1'b1}});
      @(negedge clk);
    end
    check_perf();
    run_batch(4'b1111, 1'b0, 1'b0, '0, 0, -1, 0, 0);

    // Random batches with random back-pressure and response order.
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(15, 1));
      run_batch(m, 1'($urandom), 1'b0, '0, 30, -1, 0, $urandom_range(3));
      repeat ($urandom_range(2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
